// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, field encodings and shared types for the execute stage.
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 158;
  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int ES_TO_DS_BUS_WD = 40;
  localparam int ST_B = 0;
  localparam int ST_H = 1;
  localparam int ST_W = 2;
  typedef enum logic [1:0] {DIV_NONE = 2'b00, DIV_DIV = 2'b01, DIV_MOD = 2'b10} div_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  typedef struct packed {
    logic [11:0] alu_op;
    div_op_e     div_op;
    logic        div_signed;
    logic [2:0]  st_op;
    logic [4:0]  ld_inst;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rkd_value;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] pc;
  } ds_bus_t;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: decode/execute/mem handshake, forwarding and data SRAM request signals.
interface exe_stage_if;
  import exe_stage_pkg::*;
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_we;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;
  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/alu.sv
// alu: one-hot selected integer ALU (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] sra_res;
  logic        slt, sltu;
  assign slt     = $signed(alu_src1) < $signed(alu_src2);
  assign sltu    = alu_src1 < alu_src2;
  assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];
  assign alu_result = ({32{alu_op[0]}}  & (alu_src1 + alu_src2))
                    | ({32{alu_op[1]}}  & (alu_src1 - alu_src2))
                    | ({32{alu_op[2]}}  & {31'b0, slt})
                    | ({32{alu_op[3]}}  & {31'b0, sltu})
                    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                    | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & alu_src2);
endmodule

// File: rtl/div_iter.sv
// div_iter: 32-step restoring divider on magnitudes; sign fix-up and divide-by-zero result applied on the last step.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic        ack_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);
  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q, q_n, r_n;
  logic [32:0] partial, diff;
  logic        qs_q, rs_q, zero_q, sx, sy, last;
  assign sx      = signed_i && x_i[31];
  assign sy      = signed_i && y_i[31];
  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dvs_q};
  assign q_n     = {quo_q[30:0], ~diff[32]};
  assign r_n     = diff[32] ? partial[31:0] : diff[31:0];
  assign last    = state_q == BUSY && cnt_q == 5'd31;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = BUSY;
    if (last) state_d = DONE;
    if (state_q == DONE && ack_i) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // quo_q starts as the dividend magnitude and shifts into the quotient
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_i) begin
      quo_q  <= sx ? -x_i : x_i;
      dvs_q  <= sy ? -y_i : y_i;
      rem_q  <= '0;
      cnt_q  <= '0;
      qs_q   <= sx ^ sy;
      rs_q   <= sx;
      zero_q <= y_i == '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 5'd1;
      quo_q <= !last ? q_n : zero_q ? '1 : qs_q ? -q_n : q_n;
      rem_q <= last && rs_q ? -r_n : r_n;
    end
  end
  assign done_o = state_q == DONE;
  assign quot_o = quo_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage with ALU, data SRAM request and forwarding bus.
// Define EXE_DIV_EN to include the iterative divide/modulo unit.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  exe_stage_if.master es_if
);
  ds_bus_t     es_q;
  logic        es_valid_q, es_ready_go, es_to_ms_valid, handoff;
  logic [31:0] alu_result, es_result;
  logic [3:0]  st_we;
  assign es_to_ms_valid      = es_valid_q && es_ready_go;
  assign handoff             = es_to_ms_valid && es_if.ms_allowin;
  assign es_if.es_allowin    = !es_valid_q || handoff;
  assign es_if.es_to_ms_valid = es_to_ms_valid;
  always_ff @(posedge clk) begin
    if (reset) es_valid_q <= 1'b0;
    else if (es_if.es_allowin) es_valid_q <= es_if.ds_to_es_valid;
    if (es_if.ds_to_es_valid && es_if.es_allowin) es_q <= es_if.ds_to_es_bus;
  end
  alu u_alu (
    .alu_op    (es_q.alu_op),
    .alu_src1  (es_q.alu_src1),
    .alu_src2  (es_q.alu_src2),
    .alu_result(alu_result)
  );
`ifdef EXE_DIV_EN
  logic        is_div, div_done;
  logic [31:0] div_q, div_r;
  assign is_div = es_q.div_op != DIV_NONE;
  div_iter u_div (
    .clk     (clk),
    .reset   (reset),
    .start_i (es_valid_q && is_div),
    .signed_i(es_q.div_signed),
    .x_i     (es_q.alu_src1),
    .y_i     (es_q.alu_src2),
    .ack_i   (handoff),
    .done_o  (div_done),
    .quot_o  (div_q),
    .rem_o   (div_r)
  );
  assign es_ready_go = !is_div || div_done;
  assign es_result   = !is_div ? alu_result : es_q.div_op == DIV_MOD ? div_r : div_q;
`else
  logic unused_div;
  assign unused_div  = ^{es_q.div_op, es_q.div_signed};
  assign es_ready_go = 1'b1;
  assign es_result   = alu_result;
`endif
  assign st_we = es_q.st_op[ST_B] ? 4'b0001 << alu_result[1:0]
               : es_q.st_op[ST_H] ? (alu_result[1] ? 4'b1100 : 4'b0011)
               : {4{es_q.st_op[ST_W]}};
  assign es_if.data_sram_en    = handoff && (es_q.res_from_mem || |es_q.st_op);
  assign es_if.data_sram_we    = es_if.data_sram_en ? st_we : 4'b0000;
  assign es_if.data_sram_addr  = alu_result;
  assign es_if.data_sram_wdata = es_q.st_op[ST_B] ? {4{es_q.rkd_value[7:0]}}
                               : es_q.st_op[ST_H] ? {2{es_q.rkd_value[15:0]}}
                               : es_q.rkd_value;
  assign es_if.es_to_ms_bus = {es_q.ld_inst, es_q.res_from_mem, es_q.gr_we, es_q.dest, es_result, es_q.pc};
  assign es_if.es_to_ds_bus = {es_valid_q && es_q.gr_we, es_valid_q && !es_ready_go,
                               es_valid_q && es_q.res_from_mem, es_q.dest, es_result};
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors into a scoreboard; a negedge monitor checks every handoff to mem_stage.
module tb_exe_stage;
  import exe_stage_pkg::*;
  typedef struct packed {
    logic [11:0] hdr;
    logic [31:0] res, pc, addr, wdata;
    logic        en;
    logic [3:0]  we;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  exe_stage_if ifc();
  exe_stage dut (.clk(clk), .reset(reset), .es_if(ifc));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic ds_bus_t mk(input logic [11:0] aop, input logic [1:0] dop, input logic sgn,
                                 input logic [2:0] st, input logic rfm, input logic [31:0] rkd,
                                 input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] pc);
    ds_bus_t b;
    b.alu_op       = aop;
    b.div_op       = div_op_e'(dop);
    b.div_signed   = sgn;
    b.st_op        = st;
    b.ld_inst      = rfm ? 5'b00100 : 5'b00000;
    b.res_from_mem = rfm;
    b.gr_we        = st == 3'b000;
    b.dest         = pc[6:2];
    b.rkd_value    = rkd;
    b.alu_src1     = s1;
    b.alu_src2     = s2;
    b.pc           = pc;
    return b;
  endfunction

  function automatic exp_t mke(input ds_bus_t b, input logic [31:0] res, input logic en,
                               input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.hdr   = {b.ld_inst, b.res_from_mem, b.gr_we, b.dest};
    e.res   = res;
    e.pc    = b.pc;
    e.en    = en;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && ifc.es_to_ms_valid && ifc.ms_allowin) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected handoff: pc %h result %h", ifc.es_to_ms_bus[31:0], ifc.es_to_ms_bus[63:32]);
      end else begin
        mon_e = sb.pop_front();
        chk("ms hdr", {20'b0, ifc.es_to_ms_bus[75:64]}, {20'b0, mon_e.hdr});
        chk("ms result", ifc.es_to_ms_bus[63:32], mon_e.res);
        chk("ms pc", ifc.es_to_ms_bus[31:0], mon_e.pc);
        chk("sram en", {31'b0, ifc.data_sram_en}, {31'b0, mon_e.en});
        chk("sram we", {28'b0, ifc.data_sram_we}, {28'b0, mon_e.we});
        if (mon_e.en) chk("sram addr", ifc.data_sram_addr, mon_e.addr);
        if (|mon_e.we) chk("sram wdata", ifc.data_sram_wdata, mon_e.wdata);
      end
    end
  end

  task automatic op(input string name, input ds_bus_t b, input exp_t e, input int lat, input int nbusy);
    int n = -1;
    int nb = 0;
    int w = 0;
    ifc.ds_to_es_valid = 1'b1;
    ifc.ds_to_es_bus   = b;
    while (!ifc.es_allowin && w < 100) begin
      @(negedge clk);
      w++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 ifc.ds_to_es_valid = 1'b0;
    for (int i = 0; i < 100 && n < 0; i++) begin
      @(negedge clk);
      if (ifc.es_to_ds_bus[38]) nb++;
      if (ifc.es_to_ms_valid && ifc.ms_allowin) begin
        n = i;
        chk({name, " fwd result"}, ifc.es_to_ds_bus[31:0], e.res);
      end
    end
    chk({name, " latency"}, n, lat);
    chk({name, " busy cycles"}, nb, nbusy);
  endtask

  task automatic hold(input ds_bus_t b, input exp_t e, input int lat);
    @(posedge clk);
    #1 ifc.ms_allowin = 1'b0;
    ifc.ds_to_es_valid = 1'b1;
    ifc.ds_to_es_bus   = b;
    sb.push_back(e);
    @(posedge clk);
    #1 ifc.ds_to_es_valid = 1'b0;
    repeat (lat) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid", {31'b0, ifc.es_to_ms_valid}, 32'd1);
      chk("hold allowin", {31'b0, ifc.es_allowin}, 32'd0);
      chk("hold result", ifc.es_to_ms_bus[63:32], e.res);
    end
    @(posedge clk);
    #1 ifc.ms_allowin = 1'b1;
    @(negedge clk);
    chk("release allowin", {31'b0, ifc.es_allowin}, 32'd1);
  endtask

  task automatic rst_mid(input ds_bus_t b);
    @(posedge clk);
    #1 ifc.ms_allowin = 1'b0;
    ifc.ds_to_es_valid = 1'b1;
    ifc.ds_to_es_bus   = b;
    @(posedge clk);
    #1 ifc.ds_to_es_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ifc.ms_allowin = 1'b1;
    @(negedge clk);
    chk("post-reset es_to_ms_valid", {31'b0, ifc.es_to_ms_valid}, 32'd0);
    chk("post-reset busy", {31'b0, ifc.es_to_ds_bus[38]}, 32'd0);
    chk("post-reset sram en", {31'b0, ifc.data_sram_en}, 32'd0);
    chk("post-reset allowin", {31'b0, ifc.es_allowin}, 32'd1);
  endtask

  initial begin
    ds_bus_t b;
    ifc.ds_to_es_valid = 1'b0;
    ifc.ds_to_es_bus   = '0;
    ifc.ms_allowin     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset es_to_ms_valid", {31'b0, ifc.es_to_ms_valid}, 32'd0);
    chk("reset sram en", {31'b0, ifc.data_sram_en}, 32'd0);
    chk("reset sram we", {28'b0, ifc.data_sram_we}, 32'd0);
    chk("reset ds flags", {29'b0, ifc.es_to_ds_bus[39:37]}, 32'd0);
    chk("reset allowin", {31'b0, ifc.es_allowin}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd5, 32'd7, 32'h100);
    op("add", b, mke(b, 32'd12, 1'b0, 4'b0000, 32'h0, 32'h0), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b001, 1'b0, 32'h000000A5, 32'h1000, 32'd3, 32'h104);
    op("st_b", b, mke(b, 32'h1003, 1'b1, 4'b1000, 32'h1003, 32'hA5A5A5A5), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b010, 1'b0, 32'h1234BEEF, 32'h2000, 32'd3, 32'h108);
    op("st_h hi", b, mke(b, 32'h2003, 1'b1, 4'b1100, 32'h2003, 32'hBEEFBEEF), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b010, 1'b0, 32'h1234BEEF, 32'h2000, 32'd1, 32'h10C);
    op("st_h lo", b, mke(b, 32'h2001, 1'b1, 4'b0011, 32'h2001, 32'hBEEFBEEF), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b100, 1'b0, 32'hDEADBEEF, 32'h3000, 32'd0, 32'h110);
    op("st_w", b, mke(b, 32'h3000, 1'b1, 4'b1111, 32'h3000, 32'hDEADBEEF), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b1, 32'h0, 32'h4000, 32'd4, 32'h114);
    op("load", b, mke(b, 32'h4004, 1'b1, 4'b0000, 32'h4004, 32'h0), 0, 0);
    b = mk(12'h002, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd3, 32'd5, 32'h118);
    op("sub", b, mke(b, 32'hFFFFFFFE, 1'b0, 4'b0000, 32'h0, 32'h0), 0, 0);
`ifdef EXE_DIV_EN
    b = mk(12'h001, 2'b01, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h200);
    op("sdiv -7/2", b, mke(b, 32'hFFFFFFFD, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b10, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h204);
    op("smod -7%2", b, mke(b, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 32'h12345678, 32'd0, 32'h208);
    op("udiv /0", b, mke(b, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b10, 1'b0, 3'b000, 1'b0, 32'h0, 32'h12345678, 32'd0, 32'h20C);
    op("umod /0", b, mke(b, 32'h12345678, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b01, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd0, 32'h210);
    op("sdiv -7/0", b, mke(b, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b10, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd0, 32'h214);
    op("smod -7%0", b, mke(b, 32'hFFFFFFF9, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b01, 1'b1, 3'b000, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h218);
    op("sdiv min/-1", b, mke(b, 32'h80000000, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b10, 1'b1, 3'b000, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h21C);
    op("smod min%-1", b, mke(b, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h220);
    op("udiv big/2", b, mke(b, 32'h7FFFFFFC, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b10, 1'b1, 3'b000, 1'b0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'h224);
    op("smod 7%-2", b, mke(b, 32'd1, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
    b = mk(12'h001, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 32'd100, 32'd7, 32'h228);
    hold(b, mke(b, 32'd14, 1'b0, 4'b0000, 32'h0, 32'h0), 33);
    b = mk(12'h001, 2'b01, 1'b1, 3'b000, 1'b0, 32'h0, 32'd100, 32'd7, 32'h22C);
    rst_mid(b);
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd20, 32'd22, 32'h230);
    op("add after reset", b, mke(b, 32'd42, 1'b0, 4'b0000, 32'h0, 32'h0), 0, 0);
    b = mk(12'h001, 2'b10, 1'b0, 3'b000, 1'b0, 32'h0, 32'd100, 32'd7, 32'h234);
    op("umod after reset", b, mke(b, 32'd2, 1'b0, 4'b0000, 32'h0, 32'h0), 33, 33);
`else
    b = mk(12'h001, 2'b01, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h200);
    op("div ignored", b, mke(b, 32'hFFFFFFFB, 1'b0, 4'b0000, 32'h0, 32'h0), 0, 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd100, 32'd7, 32'h228);
    hold(b, mke(b, 32'd107, 1'b0, 4'b0000, 32'h0, 32'h0), 0);
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd1, 32'd1, 32'h22C);
    rst_mid(b);
    b = mk(12'h001, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'd20, 32'd22, 32'h230);
    op("add after reset", b, mke(b, 32'd42, 1'b0, 4'b0000, 32'h0, 32'h0), 0, 0);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
